world_clock_zone_ctrl: RTL and testbench

Display scheduler for the world-clock top. It takes the single base-time BCD count (HH:MM:SS) and selects one of four city time zones to show. It applies that zone's hour offset with mod-24 wrap and drives the six BCD digit inputs of the six-digit seven-segment driver. Zone selection rotates automatically every ROT_SEC seconds in AUTO mode, or steps on a button press in MANUAL mode.

---
 rtl/world_clock_zone_ctrl_pkg.sv | 16 +
 rtl/world_clock_zone_ctrl_if.sv | 29 ++
 rtl/world_clock_zone_ctrl_bcd_hour_add.sv | 44 ++++
 rtl/world_clock_zone_ctrl.sv | 120 ++++++++++++
 tb/tb_world_clock_zone_ctrl.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/world_clock_zone_ctrl_pkg.sv
// Shared constants for the world-clock zone scheduler: zone count,
// day_shift encodings and mode FSM states.
package wc_pkg;

   localparam int unsigned NZONE = 4;

   localparam logic [1:0] DAY_SAME = 2'b00;
   localparam logic [1:0] DAY_NEXT = 2'b01;
   localparam logic [1:0] DAY_PREV = 2'b11;

   typedef enum logic {
      ST_AUTO,
      ST_MANUAL
   } mode_t;

endpackage

// File: rtl/world_clock_zone_ctrl_if.sv
// Base-time, button and display-digit bundle between the world-clock
// top and the zone scheduler.
interface world_clock_zone_ctrl_if;

   logic       tick_1hz;
   logic       btn_next;
   logic       btn_mode;
   logic [3:0] b_h_ten, b_h_one, b_m_ten, b_m_one, b_s_ten, b_s_one;
   logic [3:0] h_ten, h_one, m_ten, m_one, s_ten, s_one;
   logic [1:0] zone_idx;
   logic       auto_mode;
   logic [1:0] day_shift;
   logic       in_err;

   modport master (
      output tick_1hz, btn_next, btn_mode,
      output b_h_ten, b_h_one, b_m_ten, b_m_one, b_s_ten, b_s_one,
      input  h_ten, h_one, m_ten, m_one, s_ten, s_one,
      input  zone_idx, auto_mode, day_shift, in_err
   );

   modport slave (
      input  tick_1hz, btn_next, btn_mode,
      input  b_h_ten, b_h_one, b_m_ten, b_m_one, b_s_ten, b_s_one,
      output h_ten, h_one, m_ten, m_one, s_ten, s_one,
      output zone_idx, auto_mode, day_shift, in_err
   );

endinterface

// File: rtl/world_clock_zone_ctrl_bcd_hour_add.sv
// Combinational BCD hour + signed offset with mod-24 wrap and
// day_shift; valid flags a well-formed base hour.
module bcd_hour_add
   import wc_pkg::*;
(
   input  logic [3:0]        h_ten,
   input  logic [3:0]        h_one,
   input  logic signed [5:0] off,
   output logic [3:0]        o_ten,
   output logic [3:0]        o_one,
   output logic [1:0]        day_shift,
   output logic              valid
);

   logic [6:0]        hb;
   logic signed [6:0] s;
   logic [6:0]        hr;

   always_comb begin
      hb        = 7'(h_ten) * 7'd10 + 7'(h_one);
      valid     = (h_ten <= 4'd2) && (h_one <= 4'd9) && (hb <= 7'd23);
      s         = signed'(hb) + 7'(off);
      hr        = 7'(s);
      day_shift = DAY_SAME;
      if (s < 7'sd0) begin
         hr        = 7'(s + 7'sd24);
         day_shift = DAY_PREV;
      end else if (s >= 7'sd24) begin
         hr        = 7'(s - 7'sd24);
         day_shift = DAY_NEXT;
      end
      if (hr >= 7'd20) begin
         o_ten = 4'd2;
         o_one = 4'(hr - 7'd20);
      end else if (hr >= 7'd10) begin
         o_ten = 4'd1;
         o_one = 4'(hr - 7'd10);
      end else begin
         o_ten = 4'd0;
         o_one = 4'(hr);
      end
   end

endmodule

// File: rtl/world_clock_zone_ctrl.sv
// Zone scheduler: AUTO/MANUAL rotation over four hour offsets, with one
// register stage between the base BCD time and the display digits.
module world_clock_zone_ctrl
   import wc_pkg::*;
#(
   parameter int OFF0    = 0,
   parameter int OFF1    = 9,
   parameter int OFF2    = -5,
   parameter int OFF3    = 1,
   parameter int ROT_SEC = 5
) (
   input  logic                    clk,
   input  logic                    rst,
   world_clock_zone_ctrl_if.slave  bus
);

   mode_t             state_q, state_d;
   logic [1:0]        zone_q, zone_d;
   logic [5:0]        cnt_q, cnt_d;
   logic              adv;

   logic signed [5:0] off_sel;
   logic [3:0]        hr_ten, hr_one;
   logic [1:0]        hr_day;
   logic              hr_valid, base_valid;

   logic [3:0]        h_ten_q, h_one_q, m_ten_q, m_one_q, s_ten_q, s_one_q;
   logic [1:0]        day_q;
   logic              err_q;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= ST_AUTO;
         zone_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         zone_q  <= zone_d;
         cnt_q   <= cnt_d;
      end
   end

   // Dwell expiry and btn_next share one advance, so a coincidence steps once.
   always_comb begin
      state_d = state_q;
      zone_d  = zone_q;
      cnt_d   = cnt_q;
      adv     = bus.btn_next ||
                (state_q == ST_AUTO && bus.tick_1hz && cnt_q == 6'(ROT_SEC - 1));
      if (state_q == ST_AUTO && bus.tick_1hz)
         cnt_d = cnt_q + 6'd1;
      if (adv) begin
         zone_d = (zone_q == 2'(NZONE - 1)) ? '0 : zone_q + 2'd1;
         cnt_d  = '0;
      end
      if (bus.btn_mode) begin
         state_d = (state_q == ST_AUTO) ? ST_MANUAL : ST_AUTO;
         cnt_d   = '0;
      end
   end

   always_comb begin
      case (zone_q)
         2'd0:    off_sel = 6'(OFF0);
         2'd1:    off_sel = 6'(OFF1);
         2'd2:    off_sel = 6'(OFF2);
         default: off_sel = 6'(OFF3);
      endcase
   end

   bcd_hour_add u_hour (
      .h_ten     (bus.b_h_ten),
      .h_one     (bus.b_h_one),
      .off       (off_sel),
      .o_ten     (hr_ten),
      .o_one     (hr_one),
      .day_shift (hr_day),
      .valid     (hr_valid)
   );

   assign base_valid = hr_valid &&
                       (bus.b_m_ten <= 4'd5) && (bus.b_m_one <= 4'd9) &&
                       (bus.b_s_ten <= 4'd5) && (bus.b_s_one <= 4'd9);

   always_ff @(posedge clk) begin
      if (!rst) begin
         h_ten_q <= '0;
         h_one_q <= '0;
         m_ten_q <= '0;
         m_one_q <= '0;
         s_ten_q <= '0;
         s_one_q <= '0;
         day_q   <= DAY_SAME;
         err_q   <= 1'b0;
      end else begin
         err_q <= !base_valid;
         if (base_valid) begin
            h_ten_q <= hr_ten;
            h_one_q <= hr_one;
            m_ten_q <= bus.b_m_ten;
            m_one_q <= bus.b_m_one;
            s_ten_q <= bus.b_s_ten;
            s_one_q <= bus.b_s_one;
            day_q   <= hr_day;
         end
      end
   end

   assign bus.h_ten     = h_ten_q;
   assign bus.h_one     = h_one_q;
   assign bus.m_ten     = m_ten_q;
   assign bus.m_one     = m_one_q;
   assign bus.s_ten     = s_ten_q;
   assign bus.s_one     = s_one_q;
   assign bus.day_shift = day_q;
   assign bus.in_err    = err_q;
   assign bus.zone_idx  = zone_q;
   assign bus.auto_mode = (state_q == ST_AUTO);

endmodule

// File: tb/tb_world_clock_zone_ctrl.sv
// Directed bench for world_clock_zone_ctrl with hand-computed expectations.
module tb_world_clock_zone_ctrl;

   logic clk;
   logic rst;
   int   checks;
   int   errors;

   world_clock_zone_ctrl_if bus ();

   world_clock_zone_ctrl #(
      .OFF0    (0),
      .OFF1    (9),
      .OFF2    (-5),
      .OFF3    (1),
      .ROT_SEC (5)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic set_base(input logic [23:0] t);
      {bus.b_h_ten, bus.b_h_one, bus.b_m_ten, bus.b_m_one, bus.b_s_ten, bus.b_s_one} = t;
   endtask

   function automatic logic [31:0] shown();
      return {8'h00, bus.h_ten, bus.h_one, bus.m_ten, bus.m_one, bus.s_ten, bus.s_one};
   endfunction

   task automatic pulse_tick(input int n);
      for (int i = 0; i < n; i++) begin
         bus.tick_1hz = 1'b1;
         cyc();
         bus.tick_1hz = 1'b0;
         cyc();
      end
   endtask

   task automatic pulse_next(input int n);
      for (int i = 0; i < n; i++) begin
         bus.btn_next = 1'b1;
         cyc();
         bus.btn_next = 1'b0;
         cyc();
      end
   endtask

   task automatic pulse_mode();
      bus.btn_mode = 1'b1;
      cyc();
      bus.btn_mode = 1'b0;
      cyc();
   endtask

   initial begin
      checks = 0;
      errors = 0;
      rst = 1'b0;
      bus.tick_1hz = 1'b0;
      bus.btn_next = 1'b0;
      bus.btn_mode = 1'b0;
      set_base(24'h123456);

      // reset state
      repeat (3) cyc();
      chk("rst_digits", shown(), 32'h000000);
      chk("rst_zone", 32'(bus.zone_idx), 32'd0);
      chk("rst_auto", 32'(bus.auto_mode), 32'd1);
      chk("rst_day", 32'(bus.day_shift), 32'd0);
      chk("rst_err", 32'(bus.in_err), 32'd0);
      rst = 1'b1;
      cyc();
      cyc();
      chk("post_rst_time", shown(), 32'h123456);
      chk("post_rst_day", 32'(bus.day_shift), 32'd0);

      // zone 1 (+9): new zone shows one edge after the zone change
      set_base(24'h201507);
      bus.btn_next = 1'b1;
      cyc();
      bus.btn_next = 1'b0;
      chk("z1_zone", 32'(bus.zone_idx), 32'd1);
      chk("z1_latency", shown(), 32'h201507);
      cyc();
      chk("z1_time", shown(), 32'h051507);
      chk("z1_day", 32'(bus.day_shift), 32'b01);

      // zone 2 (-5) backward wrap
      set_base(24'h030000);
      pulse_next(1);
      chk("z2_zone", 32'(bus.zone_idx), 32'd2);
      chk("z2_time", shown(), 32'h220000);
      chk("z2_day", 32'(bus.day_shift), 32'b11);

      // zone 3 (+1) forward wrap at midnight
      set_base(24'h235959);
      pulse_next(1);
      chk("z3_zone", 32'(bus.zone_idx), 32'd3);
      chk("z3_time", shown(), 32'h005959);
      chk("z3_day", 32'(bus.day_shift), 32'b01);

      pulse_next(1);
      chk("z_wrap", 32'(bus.zone_idx), 32'd0);

      // AUTO rotation
      pulse_tick(4);
      chk("auto_4", 32'(bus.zone_idx), 32'd0);
      pulse_tick(1);
      chk("auto_5", 32'(bus.zone_idx), 32'd1);
      pulse_tick(15);
      chk("auto_20", 32'(bus.zone_idx), 32'd0);

      // btn_next coinciding with dwell expiry
      pulse_tick(4);
      bus.tick_1hz = 1'b1;
      bus.btn_next = 1'b1;
      cyc();
      bus.tick_1hz = 1'b0;
      bus.btn_next = 1'b0;
      cyc();
      chk("simul_zone", 32'(bus.zone_idx), 32'd1);
      pulse_tick(4);
      chk("simul_cnt4", 32'(bus.zone_idx), 32'd1);
      pulse_tick(1);
      chk("simul_cnt5", 32'(bus.zone_idx), 32'd2);

      // reset mid-rotation restores a full dwell period
      pulse_tick(2);
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      chk("midrst_zone", 32'(bus.zone_idx), 32'd0);
      chk("midrst_auto", 32'(bus.auto_mode), 32'd1);
      pulse_tick(4);
      chk("midrst_4", 32'(bus.zone_idx), 32'd0);
      pulse_tick(1);
      chk("midrst_5", 32'(bus.zone_idx), 32'd1);

      // MANUAL stepping
      rst = 1'b0;
      cyc();
      rst = 1'b1;
      cyc();
      pulse_mode();
      chk("man_auto", 32'(bus.auto_mode), 32'd0);
      pulse_next(3);
      chk("man_zone", 32'(bus.zone_idx), 32'd3);
      pulse_tick(10);
      chk("man_hold", 32'(bus.zone_idx), 32'd3);
      chk("man_auto2", 32'(bus.auto_mode), 32'd0);

      // btn_mode and btn_next together
      bus.btn_mode = 1'b1;
      bus.btn_next = 1'b1;
      cyc();
      bus.btn_mode = 1'b0;
      bus.btn_next = 1'b0;
      cyc();
      chk("mn_auto", 32'(bus.auto_mode), 32'd1);
      chk("mn_zone", 32'(bus.zone_idx), 32'd0);
      pulse_tick(4);
      chk("mn_cnt4", 32'(bus.zone_idx), 32'd0);
      pulse_tick(1);
      chk("mn_cnt5", 32'(bus.zone_idx), 32'd1);

      // invalid base time holds outputs
      set_base(24'h100000);
      cyc();
      cyc();
      chk("pre_inv_time", shown(), 32'h190000);
      chk("pre_inv_err", 32'(bus.in_err), 32'd0);
      set_base(24'h250000);
      cyc();
      chk("inv25_err", 32'(bus.in_err), 32'd1);
      chk("inv25_time", shown(), 32'h190000);
      chk("inv25_day", 32'(bus.day_shift), 32'd0);
      set_base(24'h240000);
      cyc();
      chk("inv24_err", 32'(bus.in_err), 32'd1);
      chk("inv24_time", shown(), 32'h190000);
      set_base(24'h236000);
      cyc();
      chk("invmin_err", 32'(bus.in_err), 32'd1);
      chk("invmin_time", shown(), 32'h190000);
      set_base(24'h23595a);
      cyc();
      chk("invdig_err", 32'(bus.in_err), 32'd1);
      chk("invdig_time", shown(), 32'h190000);
      set_base(24'h235959);
      cyc();
      chk("valid_err", 32'(bus.in_err), 32'd0);
      chk("valid_time", shown(), 32'h085959);
      chk("valid_day", 32'(bus.day_shift), 32'b01);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
